// File: rtl/iact_diag_feeder.sv
// iact_diag_feeder: pulls lockstep 12-bit iact words from the GLB lanes, packs
// each lane's lo/hi word pair into one 24-bit transfer for PE_cluster, and
// drives the per-PE iact_choose diagonal routing pattern for that transfer.
//
// Handshake rules: a GLB word is consumed on a rising clock edge where
// glb_iact_valid_i and glb_iact_ready_o are both high. A PE transfer completes
// on a rising edge where pe_iact_enable_o and pe_iact_ready_i are all ones;
// until then data, enable and choose are held stable. Partial ready does not
// complete any lane.
module iact_diag_feeder #(
  parameter int WORD_BITWIDTH      = 12,
  parameter int DATA_BITWIDTH_IACT = 24,
  parameter int NUM_GLB_IACT       = 3,
  parameter int PE_ROWS            = 3,
  parameter int PE_COLUMNS         = 4,
  parameter int NUM_WORDS          = 8,
  parameter int NUM_DIAGS          = 2,
  parameter int CHOOSE_W           = $clog2(NUM_GLB_IACT + 1)
) (
  input  logic                                       clk_i,
  input  logic                                       rst_ni,
  input  logic                                       start_i,
  output logic                                       busy_o,
  output logic                                       done_o,
  input  logic [NUM_GLB_IACT*WORD_BITWIDTH-1:0]      glb_iact_data_i,
  input  logic                                       glb_iact_valid_i,
  output logic                                       glb_iact_ready_o,
  output logic [NUM_GLB_IACT*DATA_BITWIDTH_IACT-1:0] pe_iact_data_o,
  output logic [NUM_GLB_IACT-1:0]                    pe_iact_enable_o,
  input  logic [NUM_GLB_IACT-1:0]                    pe_iact_ready_i,
  output logic [PE_COLUMNS*PE_ROWS*CHOOSE_W-1:0]     iact_choose_o,
  output logic [2:0]                                 dbg_state_o
);

  localparam int WCW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int DCW = (NUM_DIAGS > 1) ? $clog2(NUM_DIAGS) : 1;
  localparam int NPE = PE_COLUMNS * PE_ROWS;
  localparam logic [WCW-1:0] LAST_WORD = WCW'(NUM_WORDS - 1);
  localparam logic [DCW-1:0] LAST_DIAG = DCW'(NUM_DIAGS - 1);
  localparam logic [CHOOSE_W-1:0] IDLE_CODE = CHOOSE_W'(NUM_GLB_IACT);
  localparam logic [NPE*CHOOSE_W-1:0] CHOOSE_IDLE = {NPE{IDLE_CODE}};

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH_LO = 3'd1,
    S_FETCH_HI = 3'd2,
    S_SEND     = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t                                state;
  logic [WCW-1:0]                        word_cnt;
  logic [DCW-1:0]                        diag_cnt;
  logic [NUM_GLB_IACT*WORD_BITWIDTH-1:0] lo_q;

  // PE (c,r) listens to lane s-base when its anti-diagonal s=c+r falls inside
  // the current diagonal group's window; every other PE gets the idle code.
  function automatic logic [NPE*CHOOSE_W-1:0] diag_choose(input logic [DCW-1:0] diag);
    logic [NPE*CHOOSE_W-1:0] f;
    int s;
    int base;
    f    = CHOOSE_IDLE;
    base = int'(diag) * NUM_GLB_IACT;
    for (int c = 0; c < PE_COLUMNS; c++) begin
      for (int r = 0; r < PE_ROWS; r++) begin
        s = c + r;
        if (s >= base && s < base + NUM_GLB_IACT) begin
          f[(c*PE_ROWS + r)*CHOOSE_W +: CHOOSE_W] = CHOOSE_W'(s - base);
        end
      end
    end
    return f;
  endfunction

  assign dbg_state_o = state;

  // Run sequencer: all outputs are registered and updated alongside the state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state            <= S_IDLE;
      word_cnt         <= '0;
      diag_cnt         <= '0;
      lo_q             <= '0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      glb_iact_ready_o <= 1'b0;
      pe_iact_enable_o <= '0;
      pe_iact_data_o   <= '0;
      iact_choose_o    <= CHOOSE_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            state            <= S_FETCH_LO;
            word_cnt         <= '0;
            diag_cnt         <= '0;
            busy_o           <= 1'b1;
            glb_iact_ready_o <= 1'b1;
          end
        end
        S_FETCH_LO: begin
          if (glb_iact_valid_i) begin
            lo_q  <= glb_iact_data_i;
            state <= S_FETCH_HI;
          end
        end
        S_FETCH_HI: begin
          if (glb_iact_valid_i) begin
            state            <= S_SEND;
            glb_iact_ready_o <= 1'b0;
            pe_iact_enable_o <= '1;
            iact_choose_o    <= diag_choose(diag_cnt);
            for (int k = 0; k < NUM_GLB_IACT; k++) begin
              pe_iact_data_o[k*DATA_BITWIDTH_IACT +: DATA_BITWIDTH_IACT] <=
                {glb_iact_data_i[k*WORD_BITWIDTH +: WORD_BITWIDTH],
                 lo_q[k*WORD_BITWIDTH +: WORD_BITWIDTH]};
            end
          end
        end
        S_SEND: begin
          if (&pe_iact_ready_i) begin
            pe_iact_enable_o <= '0;
            iact_choose_o    <= CHOOSE_IDLE;
            if (word_cnt == LAST_WORD && diag_cnt == LAST_DIAG) begin
              state    <= S_DONE;
              done_o   <= 1'b1;
              word_cnt <= '0;
            end else begin
              state            <= S_FETCH_LO;
              glb_iact_ready_o <= 1'b1;
              if (word_cnt == LAST_WORD) begin
                word_cnt <= '0;
                diag_cnt <= diag_cnt + 1'b1;
              end else begin
                word_cnt <= word_cnt + 1'b1;
              end
            end
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          done_o <= 1'b0;
          busy_o <= 1'b0;
        end
        default: begin
          state            <= S_IDLE;
          busy_o           <= 1'b0;
          done_o           <= 1'b0;
          glb_iact_ready_o <= 1'b0;
          pe_iact_enable_o <= '0;
          iact_choose_o    <= CHOOSE_IDLE;
        end
      endcase
    end
  end

endmodule
